// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one variable-latency memory port between the IF and
//               MEM stages (data first) and drives pipeline stall/fetch-valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_take,
  input  logic              flush,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              pipe_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_INST = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_dm_req;
  logic              w_grant_data;
  logic              w_grant_inst;
  logic              r_drop;
  logic              r_dm_done;
  logic              r_if_valid;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_instr;
  logic [DATA_W-1:0] r_dm_rdata;

  assign w_dm_req = dm_read | dm_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The dm_done exclusion keeps the just-finished access from re-granting
  // in the cycle the pipeline advances, letting a waiting fetch in.
  always_comb begin
    w_state_next = r_state;
    w_grant_data = 1'b0;
    w_grant_inst = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dm_req && !r_dm_done) begin
          w_grant_data = 1'b1;
          w_state_next = S_DATA;
        end else if (if_req && !r_if_valid && !flush) begin
          w_grant_inst = 1'b1;
          w_state_next = S_INST;
        end
      end
      S_DATA:  if (mem_ack) w_state_next = S_IDLE;
      S_INST:  if (mem_ack) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop      <= 1'b0;
      r_dm_done   <= 1'b0;
      r_if_valid  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_instr  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_dm_done <= 1'b0;

      if (w_grant_data) begin
        r_mem_addr  <= dm_addr;
        r_mem_wdata <= dm_wdata;
        r_mem_we    <= dm_write;
      end else if (w_grant_inst) begin
        r_mem_addr  <= if_addr;
        r_mem_we    <= 1'b0;
      end

      if (r_state == S_DATA && mem_ack) begin
        r_dm_done <= 1'b1;
        if (!r_mem_we) r_dm_rdata <= mem_rdata;
      end

      if (r_state == S_INST) begin
        if (mem_ack)    r_drop <= 1'b0;
        else if (flush) r_drop <= 1'b1;
      end

      // A flush in the ack cycle wins over the returning instruction.
      if (if_take || flush) r_if_valid <= 1'b0;
      if (r_state == S_INST && mem_ack && !r_drop && !flush) begin
        r_if_instr <= mem_rdata;
        r_if_valid <= 1'b1;
      end
    end
  end

  assign mem_req    = (r_state != S_IDLE);
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign if_instr   = r_if_instr;
  assign if_valid   = r_if_valid;
  assign dm_rdata   = r_dm_rdata;
  assign dm_done    = r_dm_done;
  assign pipe_stall = w_dm_req & ~r_dm_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_take;
  logic        flush;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        pipe_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_take    (if_take),
    .flush      (flush),
    .if_instr   (if_instr),
    .if_valid   (if_valid),
    .dm_read    (dm_read),
    .dm_write   (dm_write),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_done    (dm_done),
    .pipe_stall (pipe_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; if_req = 0; if_addr = 0; if_take = 0; flush = 0;
    dm_read = 0; dm_write = 0; dm_addr = 0; dm_wdata = 0;
    mem_rdata = 0; mem_ack = 0;
    #1;
    rst = 1'b1; if_req = 1; if_addr = 32'h10; dm_read = 1; dm_addr = 32'h100;
    step(); step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_dm_done", {31'd0, dm_done}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_pipe_stall", {31'd0, pipe_stall}, 32'd1);
    rst = 1'b0;
    step();
    chk("post_rst_req", {31'd0, mem_req}, 32'd1);
    chk("post_rst_addr", mem_addr, 32'h100);
    chk("post_rst_we", {31'd0, mem_we}, 32'd0);
    mem_ack = 1; mem_rdata = 32'hABCD;
    step();
    chk("post_rst_done", {31'd0, dm_done}, 32'd1);
    chk("post_rst_rdata", dm_rdata, 32'hABCD);
    mem_ack = 0; dm_read = 0; if_req = 0;
    step();
    chk("post_rst_idle", {31'd0, mem_req}, 32'd0);

    // Zero-wait fetch
    if_req = 1; if_addr = 32'h10;
    step();
    chk("zf_req", {31'd0, mem_req}, 32'd1);
    chk("zf_addr", mem_addr, 32'h10);
    mem_ack = 1; mem_rdata = 32'h8C010004;
    step();
    mem_ack = 0;
    chk("zf_valid", {31'd0, if_valid}, 32'd1);
    chk("zf_instr", if_instr, 32'h8C010004);
    step();
    chk("zf_hold_valid", {31'd0, if_valid}, 32'd1);
    chk("zf_no_regrant", {31'd0, mem_req}, 32'd0);
    if_take = 1; if_req = 0;
    step();
    if_take = 0;
    chk("zf_taken", {31'd0, if_valid}, 32'd0);

    // Contention: data first, fetch follows
    dm_read = 1; dm_addr = 32'h100; if_req = 1; if_addr = 32'h20;
    #1;
    chk("ct_stall_c0", {31'd0, pipe_stall}, 32'd1);
    step();
    chk("ct_addr_c1", mem_addr, 32'h100);
    chk("ct_we_c1", {31'd0, mem_we}, 32'd0);
    chk("ct_stall_c1", {31'd0, pipe_stall}, 32'd1);
    mem_ack = 1; mem_rdata = 32'hDEAD;
    step();
    chk("ct_done_c2", {31'd0, dm_done}, 32'd1);
    chk("ct_rdata_c2", dm_rdata, 32'hDEAD);
    chk("ct_stall_c2", {31'd0, pipe_stall}, 32'd0);
    mem_ack = 0; dm_read = 0;
    step();
    chk("ct_fetch_req_c3", {31'd0, mem_req}, 32'd1);
    chk("ct_fetch_addr_c3", mem_addr, 32'h20);
    chk("ct_done_c3", {31'd0, dm_done}, 32'd0);
    mem_ack = 1; mem_rdata = 32'h0000_0777; if_req = 0;
    step();
    mem_ack = 0;
    chk("ct_fetch_valid", {31'd0, if_valid}, 32'd1);
    chk("ct_fetch_instr", if_instr, 32'h0000_0777);
    if_take = 1;
    step();
    if_take = 0;

    // Store with three wait states
    dm_write = 1; dm_addr = 32'h40; dm_wdata = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ws_req", {31'd0, mem_req}, 32'd1);
      chk("ws_we", {31'd0, mem_we}, 32'd1);
      chk("ws_addr", mem_addr, 32'h40);
      chk("ws_wdata", mem_wdata, 32'h1234);
      chk("ws_no_done", {31'd0, dm_done}, 32'd0);
      if (i == 3) begin
        mem_ack = 1; mem_rdata = 32'h5A5A;
      end
    end
    step();
    chk("ws_done", {31'd0, dm_done}, 32'd1);
    chk("ws_rdata_kept", dm_rdata, 32'hDEAD);
    mem_ack = 0; dm_write = 0;
    step();
    chk("ws_done_pulse", {31'd0, dm_done}, 32'd0);

    // Flush during an in-flight fetch
    if_req = 1; if_addr = 32'h50;
    step();
    chk("fl_req", {31'd0, mem_req}, 32'd1);
    flush = 1; if_req = 0;
    step();
    flush = 0; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    step();
    chk("fl_dropped", {31'd0, if_valid}, 32'd0);
    chk("fl_idle", {31'd0, mem_req}, 32'd0);
    mem_ack = 0; if_req = 1; if_addr = 32'h60;
    step();
    chk("fl_regrant_req", {31'd0, mem_req}, 32'd1);
    chk("fl_regrant_addr", mem_addr, 32'h60);
    mem_ack = 1; mem_rdata = 32'h1111; if_req = 0;
    step();
    mem_ack = 0;
    chk("fl_new_instr", if_instr, 32'h1111);
    chk("fl_new_valid", {31'd0, if_valid}, 32'd1);
    flush = 1;
    step();
    flush = 0;
    chk("fl_clears_valid", {31'd0, if_valid}, 32'd0);

    // Flush landing together with the fetch ack
    if_req = 1; if_addr = 32'h70;
    step();
    flush = 1; mem_ack = 1; mem_rdata = 32'h2222; if_req = 0;
    step();
    flush = 0; mem_ack = 0;
    chk("fa_dropped", {31'd0, if_valid}, 32'd0);
    chk("fa_instr_kept", if_instr, 32'h1111);

    // Read and write together acts as a store
    dm_read = 1; dm_write = 1; dm_addr = 32'h80; dm_wdata = 32'h55;
    step();
    chk("rw_we", {31'd0, mem_we}, 32'd1);
    chk("rw_wdata", mem_wdata, 32'h55);
    mem_ack = 1; mem_rdata = 32'h9999;
    step();
    mem_ack = 0; dm_read = 0; dm_write = 0;
    chk("rw_done", {31'd0, dm_done}, 32'd1);
    chk("rw_rdata_kept", dm_rdata, 32'hDEAD);
    step();

    // Reset while a data access waits
    dm_read = 1; dm_addr = 32'h90;
    step();
    step();
    chk("ra_req_wait", {31'd0, mem_req}, 32'd1);
    rst = 1;
    #1;
    chk("ra_req_drop", {31'd0, mem_req}, 32'd0);
    dm_read = 0; mem_ack = 1;
    step();
    chk("ra_no_done1", {31'd0, dm_done}, 32'd0);
    rst = 0; mem_ack = 0;
    step();
    chk("ra_no_done2", {31'd0, dm_done}, 32'd0);
    chk("ra_idle", {31'd0, mem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
